// File: rtl/svcs_rtl_pkg.sv
// Shared types for the SVCS RTL transaction path: header record,
// header word index and packer state encoding.
package svcs_rtl_pkg;

  localparam int unsigned SVCS_MAX_SIZE = 4096;

  typedef struct packed {
    logic [31:0] trnx_type;
    logic [31:0] trnx_id;
    logic [31:0] data_type;
    logic [12:0] n_payloads;
  } svcs_hdr_t;

  // Index of the header word currently held in the output register
  typedef enum logic [1:0] {
    HW_TYPE  = 2'd0,
    HW_ID    = 2'd1,
    HW_DTYPE = 2'd2,
    HW_NPAY  = 2'd3
  } svcs_hw_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PLD     = 2'd2,
    ST_PLD_CHK = 2'd3
  } svcs_state_e;

endpackage

// File: rtl/svcs_out_slice.sv
// Single-entry output register with valid/ready hold behaviour.
// Contents stay frozen while out_valid & !out_ready; the caller loads a new
// word only when can_load is high.
module svcs_out_slice #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         can_load
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  assign can_load  = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

  // Next-state: load a new word, or drop valid once the held word drains
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/svcs_trnx_packer.sv
// Packs one SVCS transaction header plus payload words into a single 32-bit
// word stream for the DPI send bridge: type, id, dtype, n_payloads, payloads.
// Optional macro SVCS_PACKER_CHECKSUM_EN appends an XOR checksum word.
module svcs_trnx_packer
  import svcs_rtl_pkg::*;
#(
  parameter int unsigned MAX_PAYLOADS = SVCS_MAX_SIZE,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdr_valid,
  output logic             hdr_ready,
  input  logic [31:0]      hdr_trnx_type,
  input  logic [31:0]      hdr_trnx_id,
  input  logic [31:0]      hdr_data_type,
  input  logic [12:0]      hdr_n_payloads,
  input  logic             pld_valid,
  output logic             pld_ready,
  input  logic [31:0]      pld_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             err_size,
  output logic [CNT_W-1:0] trnx_cnt
);

  svcs_state_e      state_q, state_d;
  svcs_hw_e         beat_q, beat_d;
  svcs_hdr_t        hdr_q, hdr_d;
  logic [12:0]      pld_cnt_q, pld_cnt_d;
  logic             err_size_q, err_size_d;
  logic [CNT_W-1:0] trnx_cnt_q, trnx_cnt_d;
`ifdef SVCS_PACKER_CHECKSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif

  logic        load, load_last, can_load;
  logic [31:0] load_data;
  logic        hdr_rdy_c, pld_rdy_c;

  // Ready is withheld while reset is asserted so nothing looks accepted
  assign hdr_ready = hdr_rdy_c & ~rst;
  assign pld_ready = pld_rdy_c & ~rst;
  assign err_size  = err_size_q;
  assign trnx_cnt  = trnx_cnt_q;

  svcs_out_slice #(.W(32)) u_out_slice (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .can_load  (can_load)
  );

  // Sequencing: beat_q names the header word now in the output register;
  // each transition decides the word loaded behind it, so the next word is
  // ready the same cycle the current one handshakes.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    hdr_d      = hdr_q;
    pld_cnt_d  = pld_cnt_q;
    err_size_d = 1'b0;
    trnx_cnt_d = trnx_cnt_q;
`ifdef SVCS_PACKER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    load       = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    hdr_rdy_c  = 1'b0;
    pld_rdy_c  = 1'b0;

    if (out_valid && out_ready && out_last) begin
      trnx_cnt_d = trnx_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        hdr_rdy_c = can_load;
        if (hdr_valid && can_load) begin
          if (hdr_n_payloads > 13'(MAX_PAYLOADS)) begin
            err_size_d = 1'b1;
          end else begin
            hdr_d.trnx_type  = hdr_trnx_type;
            hdr_d.trnx_id    = hdr_trnx_id;
            hdr_d.data_type  = hdr_data_type;
            hdr_d.n_payloads = hdr_n_payloads;
            load             = 1'b1;
            load_data        = hdr_trnx_type;
            beat_d           = HW_TYPE;
            state_d          = ST_HDR;
`ifdef SVCS_PACKER_CHECKSUM_EN
            csum_d           = hdr_trnx_type;
`endif
          end
        end
      end
      ST_HDR: begin
        if (can_load) begin
          load = 1'b1;
          unique case (beat_q)
            HW_TYPE: begin
              load_data = hdr_q.trnx_id;
              beat_d    = HW_ID;
            end
            HW_ID: begin
              load_data = hdr_q.data_type;
              beat_d    = HW_DTYPE;
            end
            HW_DTYPE: begin
              load_data = {19'b0, hdr_q.n_payloads};
              beat_d    = HW_NPAY;
              if (hdr_q.n_payloads == '0) begin
`ifdef SVCS_PACKER_CHECKSUM_EN
                state_d   = ST_PLD_CHK;
`else
                load_last = 1'b1;
                state_d   = ST_IDLE;
`endif
              end else begin
                pld_cnt_d = hdr_q.n_payloads;
                state_d   = ST_PLD;
              end
            end
            HW_NPAY: begin
              load    = 1'b0;
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_PLD: begin
        pld_rdy_c = can_load;
        if (pld_valid && can_load) begin
          load      = 1'b1;
          load_data = pld_data;
          pld_cnt_d = pld_cnt_q - 13'd1;
          if (pld_cnt_q == 13'd1) begin
`ifdef SVCS_PACKER_CHECKSUM_EN
            state_d   = ST_PLD_CHK;
`else
            load_last = 1'b1;
            state_d   = ST_IDLE;
`endif
          end
        end
      end
      ST_PLD_CHK: begin
`ifdef SVCS_PACKER_CHECKSUM_EN
        if (can_load) begin
          load      = 1'b1;
          load_data = csum_q;
          load_last = 1'b1;
          state_d   = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
    endcase

`ifdef SVCS_PACKER_CHECKSUM_EN
    if (load && (state_q == ST_HDR || state_q == ST_PLD)) begin
      csum_d = csum_q ^ load_data;
    end
`endif
  end

  // FSM, counters and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= HW_TYPE;
      hdr_q      <= '0;
      pld_cnt_q  <= '0;
      err_size_q <= 1'b0;
      trnx_cnt_q <= '0;
`ifdef SVCS_PACKER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      hdr_q      <= hdr_d;
      pld_cnt_q  <= pld_cnt_d;
      err_size_q <= err_size_d;
      trnx_cnt_q <= trnx_cnt_d;
`ifdef SVCS_PACKER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: doc/svcs_trnx_packer.md
Name: svcs_trnx_packer

Overview:
- RTL source stage that sits directly upstream of the SVCS DPI send bridge.
- Accepts one transaction header (trnx_type, trnx_id, data_type, n_payloads) plus its payload words over valid/ready.
- Emits them as a single 32-bit word stream, in the exact order the bridge forwards via svcs_dpi_send_header / svcs_dpi_hs_send_int.
- The bridge consumes one word per out handshake.

Parameters:
- MAX_PAYLOADS, 4096, largest legal n_payloads (matches SVCS_MAX_SIZE).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- hdr_valid  in  1  header presented
- hdr_ready  out  1  header accepted when hdr_valid & hdr_ready
- hdr_trnx_type  in  32  hashed transaction type
- hdr_trnx_id  in  32  transaction id
- hdr_data_type  in  32  hashed data type
- hdr_n_payloads  in  13  payload word count, 0..MAX_PAYLOADS
- pld_valid  in  1  payload word presented
- pld_ready  out  1  payload word accepted
- pld_data  in  32  payload word
- out_valid  out  1  stream word valid
- out_ready  in  1  bridge accepts word
- out_data  out  32  stream word
- out_last  out  1  final word of transaction
- err_size  out  1  one-cycle pulse: header rejected, n_payloads > MAX_PAYLOADS
- trnx_cnt  out  CNT_W  completed transactions, wraps at 2^CNT_W

Behaviour:
- Reset: async on rst high. State IDLE; out_valid=0, out_data=0, out_last=0, hdr_ready=0, pld_ready=0, err_size=0, trnx_cnt=0, all counters 0.
- Reset mid-transaction abandons the transaction; no partial resume.
- States: IDLE, HDR, PLD (PLD_CHK when the optional feature is enabled).
- IDLE:
  - hdr_ready=1 when the output register is empty or draining (!out_valid | out_ready).
  - On hdr handshake with n_payloads > MAX_PAYLOADS: pulse err_size next cycle, stay IDLE, emit nothing, no count.
  - Otherwise latch all header fields and n_payloads; go HDR with beat_cnt=0.
- HDR:
  - Emits 4 words in order: trnx_type, trnx_id, data_type, {19'b0, n_payloads}.
  - beat_cnt advances only on out handshake.
  - Word 3 has out_last=1 iff n_payloads==0 (no checksum) and returns to IDLE.
  - Else move to PLD with pld_cnt=n_payloads.
- PLD:
  - pld_ready = !out_valid | out_ready.
  - Each pld handshake loads out_data=pld_data and decrements pld_cnt.
  - Word with pld_cnt==1 carries out_last=1; then IDLE.
  - Throughput one word per cycle when out_ready held high.
- Latency: header handshake in cycle N gives out_valid with word 0 in cycle N+1. Payload word accepted in cycle M appears on out_data in M+1.
- Output register rule:
  - out_valid, out_data and out_last stay stable while out_valid & !out_ready.
  - out_valid drops the cycle after the last handshake unless a new word loads.
- Back-to-back: hdr_ready may assert in the same cycle the final word handshakes, so the next word 0 follows with zero bubble.
- trnx_cnt increments on the handshake of each out_last word.
- pld_valid outside PLD is ignored (pld_ready=0). hdr_valid outside IDLE is ignored.

Optional Feature:
- Macro: SVCS_PACKER_CHECKSUM_EN.
- Defined:
  - Running XOR of every emitted word (header and payload) is kept per transaction, reset at header accept.
  - After the last payload word (or after header word 3 when n_payloads==0), state PLD_CHK emits one extra word holding the XOR.
  - out_last moves to the checksum word. Transaction is n_payloads+5 words.
- Undefined: no checksum logic; transaction is n_payloads+4 words.

Decomposition:
- Package svcs_rtl_pkg:
  - SVCS_MAX_SIZE=4096.
  - typedef svcs_hdr_t packed struct {trnx_type, trnx_id, data_type, n_payloads}.
  - Header word-index enum HW_TYPE..HW_NPAY.
  - State enum.
- One sub-module: svcs_out_slice, the single-entry output register with valid/ready hold logic. The FSM and counters stay in svcs_trnx_packer.

Test Plan:
- Header {type=32'hA5A5_0001, id=7, dtype=32'h1234_5678, n=3}, payload 10,11,12, out_ready=1 -> words A5A50001, 7, 12345678, 3, 10, 11, 12 on consecutive cycles; out_last only on 12; trnx_cnt=1.
- n_payloads=0 -> exactly 4 words, out_last on word 3; pld_ready never asserts.
- n_payloads=4097 -> err_size pulses one cycle, out_valid stays 0, trnx_cnt unchanged; next legal header is processed normally.
- out_ready toggled 1,0,0,1 during payload -> out_data held stable while stalled; no word lost or duplicated; pld_ready low while stalled.
- Two transactions back-to-back with hdr_valid held -> word 0 of the second follows the first's last word with no idle cycle; trnx_cnt=2.
- rst asserted after header word 2 -> outputs clear immediately (async); the next transaction starts from word 0.
- With SVCS_PACKER_CHECKSUM_EN: first scenario ends with an extra word equal to the XOR of all 7 words, carrying out_last.
